// File: rtl/light_strip_tx.sv
// WS2812-style single-wire serialiser: one 24-bit colour per valid/ready handshake, MSB first, then a low latch gap.
// Optional build macro LIGHT_GRB_ORDER_EN sends G,R,B (native strip order) instead of R,G,B.
`timescale 1ns/1ps

module light_strip_tx #(
  parameter int T0H    = 40,
  parameter int T1H    = 80,
  parameter int TBIT   = 125,
  parameter int TLATCH = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] colour,
  input  logic        colour_valid,
  output logic        colour_ready,
  output logic        dout,
  output logic        busy,
  output logic        frame_done
);

  localparam int CYC_W = (TBIT > 1) ? $clog2(TBIT) : 1;
  localparam int LAT_W = (TLATCH > 1) ? $clog2(TLATCH) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TBIT - 1);
  localparam logic [CYC_W-1:0] HIGH_0   = CYC_W'(T0H);
  localparam logic [CYC_W-1:0] HIGH_1   = CYC_W'(T1H);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(TLATCH - 1);
  localparam logic [4:0]       BIT_TOP  = 5'd23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [23:0]      shift_q, shift_d;
  logic [4:0]       bit_q, bit_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             dout_q, dout_d;
  logic             frame_done_q, frame_done_d;

  logic [23:0]      tx_word;
  logic [CYC_W-1:0] cyc_inc;
  logic [CYC_W-1:0] high_time;

`ifdef LIGHT_GRB_ORDER_EN
  assign tx_word = {colour[15:8], colour[23:16], colour[7:0]};
`else
  assign tx_word = colour;
`endif

  assign cyc_inc   = cyc_q + 1'b1;
  assign high_time = shift_q[23] ? HIGH_1 : HIGH_0;

  // dout is computed one cycle ahead so the registered line is high exactly
  // while the running cycle count is below the current bit's high time.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d      = state_q;
    shift_d      = shift_q;
    bit_d        = bit_q;
    cyc_d        = cyc_q;
    lat_d        = lat_q;
    dout_d       = 1'b0;
    frame_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (colour_valid) begin
          shift_d = tx_word;
          bit_d   = BIT_TOP;
          cyc_d   = '0;
          dout_d  = 1'b1;
          state_d = SEND;
        end
      end

      SEND: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          if (bit_q != 5'd0) begin
            shift_d = {shift_q[22:0], 1'b0};
            bit_d   = bit_q - 1'b1;
            dout_d  = 1'b1;
          end else begin
            lat_d   = '0;
            state_d = LATCH;
          end
        end else begin
          cyc_d  = cyc_inc;
          dout_d = (cyc_inc < high_time);
        end
      end

      LATCH: begin
        if (lat_q == LAT_LAST) begin
          lat_d        = '0;
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // The asynchronous reset drops dout immediately and abandons any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the shift register is reset along with the control state so a
      // restart never depends on leftover data; it is a register, not a memory.
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_q        <= '0;
      cyc_q        <= '0;
      lat_q        <= '0;
      dout_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_q        <= bit_d;
      cyc_q        <= cyc_d;
      lat_q        <= lat_d;
      dout_q       <= dout_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign dout         = dout_q;
  assign frame_done   = frame_done_q;
  assign colour_ready = (state_q == IDLE);
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_light_strip_tx.sv
// Self-checking bench for light_strip_tx: directed and random frames compared
// against a cycle-level waveform model derived from the bit-coding rules.
`timescale 1ns/1ps

module tb_light_strip_tx;

  localparam int T0H    = 2;
  localparam int T1H    = 4;
  localparam int TBIT   = 6;
  localparam int TLATCH = 10;
  localparam int NBITS  = 24;
  localparam int SEND_CYCLES = NBITS * TBIT;
  localparam int FRAME  = SEND_CYCLES + TLATCH;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] colour;
  logic        colour_valid;
  logic        colour_ready;
  logic        dout;
  logic        busy;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  light_strip_tx #(
    .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TLATCH(TLATCH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .colour       (colour),
    .colour_valid (colour_valid),
    .colour_ready (colour_ready),
    .dout         (dout),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] wire_order(input logic [23:0] c);
`ifdef LIGHT_GRB_ORDER_EN
    return {c[15:8], c[23:16], c[7:0]};
`else
    return c;
`endif
  endfunction

  // Expected line level k cycles after the accepting edge.
  function automatic logic model_dout(input logic [23:0] tx, input int k);
    int b;
    if (k >= SEND_CYCLES) return 1'b0;
    b = int'(tx[NBITS - 1 - k / TBIT]);
    return (k % TBIT) < ((b != 0) ? T1H : T0H);
  endfunction

  // Present a word, follow the frame cycle by cycle and compare with the model.
  // keep_valid holds valid high and swaps colour to late_word mid-frame.
  // abort_k >= 0 pulls reset low inside cycle abort_k and returns.
  task automatic run_frame(input logic [23:0] word, input bit keep_valid,
                           input logic [23:0] late_word, input int abort_k);
    logic [23:0] tx;
    logic [23:0] decoded;
    int done_k, wave_err, hs_err, w;
    int highs[NBITS];
    tx = wire_order(word);
    colour = word;
    colour_valid = 1'b1;
    w = 0;
    while (colour_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("accept_ready", 32'(colour_ready), 32'd1);
    @(posedge clk);
    done_k = -1;
    wave_err = 0;
    hs_err = 0;
    foreach (highs[i]) highs[i] = 0;
    for (int k = 0; k <= FRAME + 20 && done_k < 0; k++) begin
      @(negedge clk);
      if (k == 0 && !keep_valid) colour_valid = 1'b0;
      if (k == 50 && keep_valid) colour = late_word;
      if (k == abort_k) begin
        check("abort_pre_dout", 32'(dout), 32'(model_dout(tx, k)));
        colour_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("abort_dout", 32'(dout), 32'd0);
        check("abort_flags", 32'({colour_ready, busy, frame_done}), 32'b100);
        return;
      end
      if (dout !== model_dout(tx, k)) wave_err++;
      if (k < SEND_CYCLES && dout === 1'b1) highs[k / TBIT]++;
      if ({colour_ready, busy} !== ((k >= FRAME) ? 2'b10 : 2'b01)) hs_err++;
      if (frame_done === 1'b1) done_k = k;
    end
    decoded = '0;
    for (int i = 0; i < NBITS; i++) decoded[NBITS - 1 - i] = (highs[i] >= 3);
    check("wave", 32'(wave_err), 32'd0);
    check("handshake", 32'(hs_err), 32'd0);
    check("done_lat", 32'(done_k), 32'(FRAME));
    check("decoded", 32'(decoded), 32'(tx));
    if (!keep_valid) begin
      @(negedge clk);
      check("post_idle", 32'({dout, colour_ready, busy, frame_done}), 32'b0100);
    end
  endtask

  initial begin
    int fd_seen, ready_low, idle;
    bit keep;
    logic [23:0] w1, w2;

    rst = 1'b0;
    colour = '0;
    colour_valid = 1'b0;
    #1 check("rst_async", 32'({dout, colour_ready, busy, frame_done}), 32'b0100);
    repeat (3) begin
      @(negedge clk);
      check("rst_hold", 32'({dout, colour_ready, busy, frame_done}), 32'b0100);
    end
    rst = 1'b1;
    @(negedge clk);
    check("rst_release", 32'({dout, colour_ready, busy, frame_done}), 32'b0100);

    run_frame(24'hFFFFFF, 1'b0, 24'h0, -1);
    run_frame(24'h000000, 1'b0, 24'h0, -1);
    run_frame(24'hA50F3C, 1'b0, 24'h0, -1);

    // Late colour change must not disturb the frame in flight; accepted right after frame_done.
    run_frame(24'h00FF00, 1'b1, 24'h123456, -1);
    run_frame(24'h123456, 1'b0, 24'h0, -1);

    // Reset inside the high pulse of bit 10.
    run_frame(24'hFFFFFF, 1'b0, 24'h0, 10 * TBIT + 1);
    repeat (2) @(negedge clk);
    check("abort_hold", 32'({dout, colour_ready, busy, frame_done}), 32'b0100);
    rst = 1'b1;
    fd_seen = 0;
    ready_low = 0;
    repeat (FRAME + 10) begin
      @(negedge clk);
      if (frame_done === 1'b1) fd_seen++;
      if (colour_ready !== 1'b1) ready_low++;
    end
    check("abort_no_done", 32'(fd_seen), 32'd0);
    check("abort_idle", 32'(ready_low), 32'd0);
    run_frame(24'($urandom), 1'b0, 24'h0, -1);

    for (int i = 0; i < 6; i++) begin
      idle = $urandom_range(0, 3);
      repeat (idle) @(negedge clk);
      keep = 1'($urandom_range(0, 1));
      w1 = 24'($urandom);
      w2 = 24'($urandom);
      run_frame(w1, keep, w2, -1);
      if (keep) run_frame(w2, 1'b0, 24'h0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/light_strip_tx.md
Name: light_strip_tx

Overview:
- Serialises one 24-bit RGB colour word, as produced by the lights selector, onto a single-wire LED strip data line.
- Uses WS2812-style pulse-width bit coding.
- Accepts one colour per valid/ready handshake, shifts it out MSB first, then holds a low latch gap so the strip commits the colour.
- Sits between the lights selector output and the board LED pin.

Parameters:
- T0H, 40, high time in clk cycles for a 0 bit.
- T1H, 80, high time in clk cycles for a 1 bit.
- TBIT, 125, total bit period in clk cycles. Legal only if 0 < T0H < T1H < TBIT.
- TLATCH, 5000, low latch gap in clk cycles after the last bit. Must be at least 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset; 0 resets the block immediately.
- colour  input  24  colour word {R[7:0], G[7:0], B[7:0]}.
- colour_valid  input  1  colour holds a word to send.
- colour_ready  output  1  block can accept a word; high only in IDLE.
- dout  output  1  registered serial data line to the strip.
- busy  output  1  high in SEND and LATCH.
- frame_done  output  1  one-cycle pulse when the latch gap completes.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, dout=0, busy=0, frame_done=0, colour_ready=1.
  - Shift register and all counters cleared.
- States: IDLE, SEND, LATCH.
- IDLE:
  - colour_ready=1, dout=0.
  - On a rising edge with colour_valid=1, the word is accepted: the shift register loads the transmit order, bit counter=23, cycle counter=0, state=SEND.
  - dout goes to 1 on that same edge.
  - colour_ready and busy update on that edge: colour_ready=0, busy=1.
- SEND:
  - Current bit is the shift register MSB.
  - Cycle counter runs 0..TBIT-1.
  - dout=1 while counter < THIGH, else 0. THIGH is T1H for a 1 bit and T0H for a 0 bit.
  - When the counter reaches TBIT-1:
    - If bit counter>0: shift left, decrement bit counter, reset cycle counter to 0, and set dout=1 on that edge. Bit n therefore starts exactly n*TBIT cycles after acceptance.
    - After bit counter 0 completes: state=LATCH, dout=0, cycle counter=0.
- LATCH:
  - dout=0 for TLATCH cycles.
  - On the final cycle: frame_done=1 for exactly one cycle, state=IDLE, colour_ready=1, busy=0.
- Latency: frame_done is asserted 24*TBIT + TLATCH cycles after the accepting edge.
- A word presented with colour_valid=1 on the same cycle frame_done is high is accepted on the next edge. Minimum gap between frames is one IDLE cycle.
- colour and colour_valid are ignored while busy. No input buffering; the source must hold valid until ready.
- The colour word is captured at acceptance. Changes to colour during SEND do not alter the frame in flight.
- Reset mid-frame: dout drops to 0 immediately. The frame is abandoned with no frame_done, and the block restarts in IDLE on release.
- All counters are sized by $clog2 of their parameter and never wrap within a frame.

Optional Feature:
- Macro: LIGHT_GRB_ORDER_EN.
- Defined: transmit order is G[7:0], R[7:0], B[7:0] (native strip order). The shift register loads {G,R,B}.
- Undefined: transmit order is R, G, B exactly as presented on colour. The shift register loads colour unchanged.
- Timing, handshake and latency are identical in both builds.

Test Plan:
Bench parameters: T0H=2, T1H=4, TBIT=6, TLATCH=10, clk period 10 ns.
1. Hold rst=0 for 3 cycles, then release -> dout=0, colour_ready=1, busy=0, frame_done=0 throughout reset and on the first cycle after release.
2. Send colour=24'hFFFFFF with a 1-cycle valid -> 24 high pulses of 4 cycles, period 6; dout low 10 cycles; frame_done pulses exactly 154 cycles after acceptance; colour_ready returns to 1.
3. Send colour=24'h000000 -> 24 high pulses of 2 cycles, period 6; frame_done at 154 cycles.
4. Send colour=24'hA50F3C and decode pulse widths into bits:
   - Macro undefined -> bits read 0xA5, 0x0F, 0x3C.
   - LIGHT_GRB_ORDER_EN defined -> bits read 0x0F, 0xA5, 0x3C.
5. Assert valid with 24'h00FF00, then change to 24'h123456 mid-frame with valid still high:
   - First frame decodes as 24'h00FF00.
   - colour_ready stays 0 until frame_done.
   - 24'h123456 is accepted on the edge after frame_done and decodes correctly.
6. Pull rst low during a high pulse at bit 10 -> dout=0 before the next clk edge; no frame_done; after release colour_ready=1 and a new word sends a full 24-bit frame.
